// File: rtl/uart_proto_pkg.sv
// Shared UART link protocol definitions: byte tag encoding, payload width and link FSM states.
// The send multiplexer uses the same tag constants, so the two sides always agree on framing.
package uart_proto_pkg;

  localparam int BYTE_W    = 8;
  localparam int TAG_W     = 2;
  localparam int PAYLOAD_W = BYTE_W - TAG_W;

  localparam logic [TAG_W-1:0] TAG_INVALID = 2'b00;
  localparam logic [TAG_W-1:0] TAG_TARGET  = 2'b01;
  localparam logic [TAG_W-1:0] TAG_MACHINE = 2'b10;
  localparam logic [TAG_W-1:0] TAG_STATE   = 2'b11;

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_t;

  function automatic logic tag_is_valid(input logic [TAG_W-1:0] tag);
    return tag != TAG_INVALID;
  endfunction

endpackage

// File: rtl/link_watchdog.sv
// Host-link watchdog: counts cycles since the last kick and flags expiry on the final count.
// A kick on the expiry cycle masks expiry, so a late-but-valid byte keeps the link up.
module link_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic uart_clk,
  input  logic rst,
  input  logic kick,
  output logic expired
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (kick) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_LAST) && !kick;

endmodule

// File: rtl/recv_data_decoder.sv
// Receive-side decoder: routes tagged UART bytes into three feedback registers with change strobes,
// tracks host link health through a watchdog-driven FSM and counts invalid-tag bytes.
module recv_data_decoder
  import uart_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ERR_W          = 8
) (
  input  logic                 uart_clk,
  input  logic                 rst,
  input  logic [BYTE_W-1:0]    rx_data,
  input  logic                 rx_valid,
  output logic [PAYLOAD_W-1:0] feedback_target,
  output logic [PAYLOAD_W-1:0] feedback_machine,
  output logic [PAYLOAD_W-1:0] feedback_state,
  output logic                 target_upd,
  output logic                 machine_upd,
  output logic                 state_upd,
  output logic                 link_alive,
  output logic [ERR_W-1:0]     bad_byte_cnt
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  logic [BYTE_W-1:0]    rx_data_p0;
  logic                 vld_p0;
  logic [TAG_W-1:0]     tag_p0;
  logic [PAYLOAD_W-1:0] payload_p0;
  logic                 kick_p0;
  logic                 resync_p0;
  logic                 load_target_p0;
  logic                 load_machine_p0;
  logic                 load_state_p0;
  logic                 bad_p0;
  logic                 expired;
  link_state_t          state;
  link_state_t          state_nxt;

  // Stage p0: capture the received byte; only its valid flag is reset.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rx_valid;
    end
  end

  always_ff @(posedge uart_clk) begin
    rx_data_p0 <= rx_data;
  end

  assign tag_p0     = rx_data_p0[TAG_W-1:0];
  assign payload_p0 = rx_data_p0[BYTE_W-1:TAG_W];
  assign kick_p0    = vld_p0 && tag_is_valid(tag_p0);
  assign bad_p0     = vld_p0 && (tag_p0 == TAG_INVALID);

  // After a link loss every register reloads and strobes, even when the value is unchanged.
  assign resync_p0       = (state == LINK_DOWN);
  assign load_target_p0  = vld_p0 && (tag_p0 == TAG_TARGET)
                           && ((payload_p0 != feedback_target) || resync_p0);
  assign load_machine_p0 = vld_p0 && (tag_p0 == TAG_MACHINE)
                           && ((payload_p0 != feedback_machine) || resync_p0);
  assign load_state_p0   = vld_p0 && (tag_p0 == TAG_STATE)
                           && ((payload_p0 != feedback_state) || resync_p0);

  link_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .uart_clk(uart_clk),
    .rst     (rst),
    .kick    (kick_p0),
    .expired (expired)
  );

  // Stage p1: feedback registers, change strobes and error counter.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      feedback_target  <= '0;
      feedback_machine <= '0;
      feedback_state   <= '0;
      target_upd       <= 1'b0;
      machine_upd      <= 1'b0;
      state_upd        <= 1'b0;
      bad_byte_cnt     <= '0;
    end else begin
      target_upd  <= load_target_p0;
      machine_upd <= load_machine_p0;
      state_upd   <= load_state_p0;
      if (load_target_p0) begin
        feedback_target <= payload_p0;
      end
      if (load_machine_p0) begin
        feedback_machine <= payload_p0;
      end
      if (load_state_p0) begin
        feedback_state <= payload_p0;
      end
      if (bad_p0) begin
        bad_byte_cnt <= sat_inc(bad_byte_cnt);
      end
    end
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state <= LINK_DOWN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LINK_DOWN: if (kick_p0) state_nxt = LINK_UP;
      LINK_UP:   if (expired) state_nxt = LINK_DOWN;
      default:   state_nxt = LINK_DOWN;
    endcase
  end

  always_comb begin
    link_alive = (state == LINK_UP);
  end

endmodule

// File: tb/tb_recv_data_decoder.sv
// Directed bench for recv_data_decoder: a behavioural model queues the expected outputs per edge,
// and each sampled cycle pops and compares them alongside a few explicit directed checks.
module tb_recv_data_decoder;

  localparam int TO = 16;
  localparam int EW = 8;

  logic          uart_clk = 1'b0;
  logic          rst      = 1'b1;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic [5:0]    feedback_target;
  logic [5:0]    feedback_machine;
  logic [5:0]    feedback_state;
  logic          target_upd;
  logic          machine_upd;
  logic          state_upd;
  logic          link_alive;
  logic [EW-1:0] bad_byte_cnt;

  typedef struct packed {
    logic [5:0]    tgt;
    logic [5:0]    mach;
    logic [5:0]    st;
    logic          tu;
    logic          mu;
    logic          su;
    logic          alive;
    logic [EW-1:0] bad;
  } snap_t;

  snap_t q[$];
  snap_t m;
  int    m_cnt;
  int    checks = 0;
  int    errors = 0;

  always #5 uart_clk = ~uart_clk;

  recv_data_decoder #(
    .TIMEOUT_CYCLES(TO),
    .ERR_W         (EW)
  ) dut (
    .uart_clk        (uart_clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .feedback_target (feedback_target),
    .feedback_machine(feedback_machine),
    .feedback_state  (feedback_state),
    .target_upd      (target_upd),
    .machine_upd     (machine_upd),
    .state_upd       (state_upd),
    .link_alive      (link_alive),
    .bad_byte_cnt    (bad_byte_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one processed byte slot; pushes the outputs expected one edge later.
  task automatic model_advance(input logic v, input logic [7:0] d);
    logic kick;
    logic expd;
    kick = v && (d[1:0] != 2'b00);
    expd = (m_cnt == TO - 1) && !kick;
    m.tu = 1'b0;
    m.mu = 1'b0;
    m.su = 1'b0;
    if (v) begin
      case (d[1:0])
        2'b00: if (m.bad != {EW{1'b1}}) m.bad = m.bad + 1'b1;
        2'b01: if (d[7:2] != m.tgt || !m.alive) begin m.tgt = d[7:2]; m.tu = 1'b1; end
        2'b10: if (d[7:2] != m.mach || !m.alive) begin m.mach = d[7:2]; m.mu = 1'b1; end
        default: if (d[7:2] != m.st || !m.alive) begin m.st = d[7:2]; m.su = 1'b1; end
      endcase
    end
    if (kick) m.alive = 1'b1;
    else if (expd) m.alive = 1'b0;
    m_cnt = kick ? 0 : ((m_cnt == TO - 1) ? m_cnt : m_cnt + 1);
    q.push_back(m);
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    snap_t e;
    @(negedge uart_clk);
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    if (r) begin
      q.delete();
      m     = '0;
      m_cnt = 0;
      q.push_back(m);
      model_advance(1'b0, 8'h00);
    end else begin
      model_advance(v, d);
    end
    @(posedge uart_clk);
    #1;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: observed 0 entries required 1");
    end else begin
      e = q.pop_front();
      chk("feedback_target",  feedback_target,  e.tgt);
      chk("feedback_machine", feedback_machine, e.mach);
      chk("feedback_state",   feedback_state,   e.st);
      chk("target_upd",       target_upd,       e.tu);
      chk("machine_upd",      machine_upd,      e.mu);
      chk("state_upd",        state_upd,        e.su);
      chk("link_alive",       link_alive,       e.alive);
      chk("bad_byte_cnt",     bad_byte_cnt,     e.bad);
    end
  endtask

  initial begin
    m     = '0;
    m_cnt = 0;

    // Reset, with a byte presented on a reset edge, then idle.
    step(1'b1, 1'b1, 8'h29);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    chk("rst_alive", link_alive, 0);
    chk("rst_target", feedback_target, 0);
    chk("rst_bad", bad_byte_cnt, 0);

    // Target register: first load, repeat suppression, value change.
    step(1'b0, 1'b1, 8'h29);
    step(1'b0, 1'b0, 8'h00);
    chk("t2_target", feedback_target, 6'h0A);
    chk("t2_pulse", target_upd, 1);
    chk("t2_alive", link_alive, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("t2_pulse_end", target_upd, 0);
    step(1'b0, 1'b1, 8'h29);
    step(1'b0, 1'b0, 8'h00);
    chk("t2_repeat_nopulse", target_upd, 0);
    step(1'b0, 1'b1, 8'h2D);
    step(1'b0, 1'b0, 8'h00);
    chk("t2_target_b", feedback_target, 6'h0B);
    chk("t2_pulse_b", target_upd, 1);

    // Back-to-back machine and state bytes.
    step(1'b0, 1'b1, 8'hFE);
    step(1'b0, 1'b1, 8'hFF);
    chk("t3_machine", feedback_machine, 6'h3F);
    chk("t3_machine_upd", machine_upd, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("t3_state", feedback_state, 6'h3F);
    chk("t3_state_upd", state_upd, 1);
    chk("t3_machine_upd_end", machine_upd, 0);

    // Invalid-tag flood saturates the error counter.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, {6'($urandom), 2'b00});
    step(1'b0, 1'b0, 8'h00);
    chk("t4_bad_sat", bad_byte_cnt, 8'hFF);
    chk("t4_target_held", feedback_target, 6'h0B);
    chk("t4_machine_held", feedback_machine, 6'h3F);

    // Resync after link loss, exact timeout, then resync again.
    step(1'b0, 1'b1, 8'h2D);
    step(1'b0, 1'b0, 8'h00);
    chk("t5_resync_pulse", target_upd, 1);
    chk("t5_alive", link_alive, 1);
    repeat (15) step(1'b0, 1'b0, 8'h00);
    chk("t5_alive_last", link_alive, 1);
    step(1'b0, 1'b0, 8'h00);
    chk("t5_alive_fall", link_alive, 0);
    step(1'b0, 1'b1, 8'h2D);
    step(1'b0, 1'b0, 8'h00);
    chk("t5_resync_pulse2", target_upd, 1);

    // Byte landing on the expiry cycle keeps the link up.
    repeat (14) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h2D);
    step(1'b0, 1'b0, 8'h00);
    chk("t5_expiry_byte_alive", link_alive, 1);
    chk("t5_expiry_byte_nopulse", target_upd, 0);
    repeat (3) step(1'b0, 1'b0, 8'h00);
    chk("t5_still_alive", link_alive, 1);

    // Reset right after a byte suppresses its pulse; next byte resyncs.
    step(1'b0, 1'b1, 8'h35);
    step(1'b1, 1'b0, 8'h00);
    chk("t6_no_pulse", target_upd, 0);
    chk("t6_target_clr", feedback_target, 0);
    chk("t6_alive_clr", link_alive, 0);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b0, 8'h00);
    chk("t6_resync_pulse", target_upd, 1);
    chk("t6_target_zero", feedback_target, 0);
    chk("t6_alive", link_alive, 1);
    step(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
